// File: rtl/cheese_spawner_pkg.sv
// cheese_spawner_pkg: position type, spawn table, park spot and FSM states for the cheese spawner.
package cheese_spawner_pkg;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
    } pos_t;
    typedef enum logic [1:0] {SHOW, HIDE, PLACE, DONE} cheese_spawn_state_t;
    localparam logic [10:0] CHEESE_PARK_X = 11'd1100;
    localparam logic [10:0] CHEESE_PARK_Y = 11'd900;
    // every spot keeps a 32x32 sprite fully inside 1024x768
    localparam pos_t CHEESE_SPOTS [8] = '{
        '{11'd100, 11'd100}, '{11'd900, 11'd120}, '{11'd480, 11'd360}, '{11'd200, 11'd600},
        '{11'd800, 11'd650}, '{11'd60,  11'd400}, '{11'd700, 11'd300}, '{11'd350, 11'd180}
    };
endpackage

// File: rtl/pos_if.sv
// pos_if: sprite top-left position bundle shared by a writer and its readers.
interface pos_if;
    logic [10:0] x;
    logic [10:0] y;
    modport out(output x, y);
    modport sink(input x, y);
endinterface

// File: rtl/cheese_lfsr.sv
// cheese_lfsr: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, loaded from seed on rst_n.
module cheese_lfsr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    output logic [15:0] out
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) out <= seed;
        else        out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
endmodule

// File: rtl/cheese_spawner.sv
// cheese_spawner: owns the cheese position; parks it after a take and re-places it
// at a table spot different from the last one once the respawn delay expires.
module cheese_spawner
    import cheese_spawner_pkg::*;
#(
    parameter int unsigned RESPAWN_DLY = 32_500_000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reset,
    input  logic cheese_taken,
    input  logic cheese_gm,
    pos_if.out   cheesepos,
    output logic cheese_visible,
    output logic spawn_strobe
);
    localparam logic [25:0] DLY_M1 = 26'(RESPAWN_DLY - 1);
    localparam pos_t        PARK   = '{CHEESE_PARK_X, CHEESE_PARK_Y};

    cheese_spawn_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d, new_idx;
    pos_t        pos_q, pos_d;
    logic        vis_q, vis_d, stb_q, stb_d;
    logic [25:0] cnt_q, cnt_d;
    logic [15:0] lfsr;
    logic        lfsr_unused;

    cheese_lfsr u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .seed (LFSR_SEED),
        .out  (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:3];
    // never re-place on the spot just taken
    assign new_idx = (lfsr[2:0] == idx_q) ? idx_q + 3'd1 : lfsr[2:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        vis_d   = vis_q;
        stb_d   = 1'b0;
        cnt_d   = cnt_q;
        if (reset) begin
            state_d = SHOW;
            idx_d   = '0;
            pos_d   = CHEESE_SPOTS[0];
            vis_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SHOW: if (cheese_taken) begin
                    state_d = cheese_gm ? DONE : HIDE;
                    cnt_d   = '0;
                    vis_d   = 1'b0;
                    pos_d   = PARK;
                end
                HIDE: begin
                    cnt_d   = cnt_q + 26'd1;
                    state_d = (cnt_q == DLY_M1) ? PLACE : HIDE;
                end
                PLACE: begin
                    state_d = SHOW;
                    idx_d   = new_idx;
                    pos_d   = CHEESE_SPOTS[new_idx];
                    vis_d   = 1'b1;
                    stb_d   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= SHOW;
            idx_q   <= '0;
            pos_q   <= CHEESE_SPOTS[0];
            vis_q   <= 1'b1;
            stb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            vis_q   <= vis_d;
            stb_q   <= stb_d;
            cnt_q   <= cnt_d;
        end

    assign cheesepos.x    = pos_q.x;
    assign cheesepos.y    = pos_q.y;
    assign cheese_visible = vis_q;
    assign spawn_strobe   = stb_q;
endmodule

// File: tb/tb_cheese_spawner.sv
// tb_cheese_spawner: vector table plus directed sequences; respawn spots are predicted
// from an independent LFSR model and queued when the take is driven.
module tb_cheese_spawner;
    import cheese_spawner_pkg::*;
    localparam int          D    = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam pos_t        PARK = '{11'd1100, 11'd900};

    typedef struct packed {
        bit       rs, tk, g, push, vis, stb;
        bit [1:0] kind;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, reset = 1'b0, cheese_taken = 1'b0, cheese_gm = 1'b0;
    logic vis, stb;
    logic [15:0] m_lfsr;
    int checks = 0, errors = 0, exp_idx = 0, wraps = 0;
    int sb[$];
    pos_t last_pos;

    pos_if cp();

    cheese_spawner #(.RESPAWN_DLY(D), .LFSR_SEED(SEED)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reset         (reset),
        .cheese_taken  (cheese_taken),
        .cheese_gm     (cheese_gm),
        .cheesepos     (cp),
        .cheese_visible(vis),
        .spawn_strobe  (stb)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [2:0] cand_at(input logic [15:0] l, input int n);
        for (int i = 0; i < n; i++) l = nxt(l);
        return l[2:0];
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= nxt(m_lfsr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // kind: 1 parked, 2 new spot from scoreboard, 3 current spot
    task automatic step(input bit rs, tk, g, push, ev, es, input int kind, input string nm);
        pos_t ep;
        int c;
        if (push) begin
            c = int'(cand_at(m_lfsr, D + 1));
            if (c == exp_idx && exp_idx == 7) wraps++;
            sb.push_back(c == exp_idx ? (exp_idx + 1) % 8 : c);
        end
        reset = rs;
        cheese_taken = tk;
        cheese_gm = g;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cheese_taken = 1'b0;
        cheese_gm = 1'b0;
        if (rs) begin
            sb.delete();
            exp_idx = 0;
        end
        if (kind == 2) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s: scoreboard empty, no respawn expected", nm);
            end else begin
                exp_idx = sb.pop_front();
                chk({nm, "_moved"}, 32'({cp.x, cp.y} != last_pos), 32'd1);
            end
        end
        ep = (kind == 1) ? PARK : CHEESE_SPOTS[exp_idx];
        chk(nm, {8'd0, vis, stb, cp.x, cp.y}, {8'd0, ev, es, ep});
        if (vis) last_pos = {cp.x, cp.y};
    endtask

    task automatic take_and_respawn(input string nm);
        step(0, 1, 0, 1, 0, 0, 1, nm);
        for (int i = 0; i < D; i++) step(0, 0, 0, 0, 0, 0, 1, nm);
        step(0, 0, 0, 0, 1, 1, 2, nm);
    endtask

    // fields: rs tk g push _ vis stb _ kind
    vec_t tbl [20] = '{
        8'b0000_10_11, 8'b0101_00_01, 8'b0100_00_01, 8'b0000_00_01, 8'b0110_00_01,
        8'b0000_00_01, 8'b0000_11_10, 8'b0000_10_11, 8'b0101_00_01, 8'b0000_00_01,
        8'b0000_00_01, 8'b1000_10_11, 8'b0000_10_11, 8'b0000_10_11, 8'b0000_10_11,
        8'b0000_10_11, 8'b1100_10_11, 8'b0000_10_11, 8'b0110_00_01, 8'b0000_00_01
    };

    initial begin
        #22;
        chk("rst_low", {8'd0, vis, stb, cp.x, cp.y}, {8'd0, 1'b1, 1'b0, CHEESE_SPOTS[0]});
        last_pos = CHEESE_SPOTS[0];
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 1, 0, 3, "idle");
        for (int i = 0; i < 20; i++)
            step(tbl[i].rs, tbl[i].tk, tbl[i].g, tbl[i].push, tbl[i].vis, tbl[i].stb,
                 int'(tbl[i].kind), $sformatf("vec%0d", i));
        for (int i = 0; i < 1000; i++) step(0, i % 7 == 0, 1'(i % 2), 0, 0, 0, 1, "done");
        step(1, 0, 0, 0, 1, 0, 3, "done_reset");
        chk("lfsr_cont", 32'(dut.u_lfsr.out), 32'(m_lfsr));
        take_and_respawn("after_reset");
        step(0, 1, 0, 1, 0, 0, 1, "async_take");
        step(0, 0, 0, 0, 0, 0, 1, "async_hide");
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst", {8'd0, vis, stb, cp.x, cp.y}, {8'd0, 1'b1, 1'b0, CHEESE_SPOTS[0]});
        chk("async_lfsr", 32'(dut.u_lfsr.out), 32'(SEED));
        #2 rst_n = 1'b1;
        sb.delete();
        exp_idx = 0;
        last_pos = CHEESE_SPOTS[0];
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, 3, "post_async");
        for (int t = 0; t < 200; t++) begin
            int gap;
            gap = $urandom_range(0, 7);
            if (t % 4 == 0 || exp_idx == 7)
                for (int g = 63; g >= 0; g--)
                    if (int'(cand_at(m_lfsr, g + D + 1)) == exp_idx) gap = g;
            for (int i = 0; i < gap; i++) step(0, 0, 0, 0, 1, 0, 3, "gap");
            take_and_respawn("rand");
        end
        chk("wrap_seen", 32'(wraps > 0), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
